// File: rtl/camera_pkg.sv
// Shared types and helpers for the camera basis pipeline.
//   vec3_pos_t / vec3_sc_t : 3-element packed vectors at the default widths.
//   vec3_w_t               : 3 x 32-bit working vector for width-generic helpers.
//   sat_neg                : negation that clamps the most negative value.
//   sat_add3               : per-axis saturating add with an OR'ed overflow flag.
//   pipe_latency           : input-transfer to valid_out latency in cycles.
package camera_pkg;

    localparam int unsigned SC_W_DEF        = 16;
    localparam int unsigned POS_W_DEF       = 18;
    localparam int unsigned MULT_STAGES_DEF = 2;

    typedef logic [2:0][POS_W_DEF-1:0] vec3_pos_t;
    typedef logic [2:0][SC_W_DEF-1:0]  vec3_sc_t;
    typedef logic [2:0][31:0]          vec3_w_t;

    typedef struct packed {
        logic    ovf;
        vec3_w_t sum;
    } sat3_t;

    // Input register + two multiplier layers + saturating output register.
    function automatic int unsigned pipe_latency(input int unsigned mult_stages);
        return 2 * mult_stages + 2;
    endfunction

    // x is a sign-extended w-bit value; -(-2^(w-1)) clamps to 2^(w-1)-1.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x,
                                                   input int unsigned       w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        return (x == lo) ? hi : -x;
    endfunction

    // a and b hold sign-extended w-bit values (w <= 30 so the sum cannot wrap).
    function automatic sat3_t sat_add3(input vec3_w_t     a,
                                       input vec3_w_t     b,
                                       input int unsigned w);
        sat3_t              r;
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        r  = '0;
        for (int i = 0; i < 3; i++) begin
            s = signed'(a[i]) + signed'(b[i]);
            if (s > hi) begin
                r.sum[i] = hi;
                r.ovf    = 1'b1;
            end else if (s < lo) begin
                r.sum[i] = lo;
                r.ovf    = 1'b1;
            end else begin
                r.sum[i] = s;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fixed_point_mult.sv
// Pipelined signed fixed-point multiplier: p = trunc_WO((a * b) >>> FRAC).
//   clk_i, rst_ni : clock, async active-low clear
//   en_i          : pipeline enable (held low during a global stall)
//   a_i, b_i      : signed operands (WA / WB bits)
//   p_o           : signed product, STAGES enabled cycles after the operands
module fixed_point_mult #(
    parameter int unsigned WA     = 16,
    parameter int unsigned WB     = 16,
    parameter int unsigned WO     = 16,
    parameter int unsigned FRAC   = 14,
    parameter int unsigned STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic signed [WA-1:0] a_i,
    input  logic signed [WB-1:0] b_i,
    output logic signed [WO-1:0] p_o
);

    localparam int unsigned PW = WA + WB;

    logic signed [PW-1:0] prod_full;
    logic        [WO-1:0] prod_trunc;
    logic        [WO-1:0] prod_q;

    // Full-width product is exact; truncation to WO bits happens after the shift.
    assign prod_full  = PW'(a_i) * PW'(b_i);
    assign prod_trunc = WO'(prod_full >>> FRAC);

    stall_delay #(
        .WIDTH(WO),
        .DEPTH(STAGES)
    ) u_pipe (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en_i  (en_i),
        .d_i   (prod_trunc),
        .q_o   (prod_q)
    );

    assign p_o = prod_q;

endmodule

// File: rtl/stall_delay.sv
// Enabled shift register with async active-low clear.
//   clk_i, rst_ni : clock, async active-low clear
//   en_i          : advance the line when high, hold otherwise
//   d_i / q_o     : WIDTH-bit data in / data DEPTH enabled cycles later
module stall_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] sr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else if (en_i) begin
            sr_q[0] <= d_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/camera_basis_pipe.sv
// Camera basis (u, v, n) and orbit position generator with valid/ready on both sides.
//   clk_in, rst_n_in          : clock, async active-low reset
//   cos/sin_phi_in, cos/sin_theta_in : signed FRAC fixed-point angle terms
//   mag_in, target_in         : orbit radius and centre (x in the low slice)
//   valid_in / ready_out      : input handshake
//   pos_out, u_out, v_out, n_out : results, x component in the low slice
//   ovf_out                   : position clamped on at least one axis
//   valid_out / ready_in      : output handshake
module camera_basis_pipe
    import camera_pkg::*;
#(
    parameter int unsigned FRAC         = 14,
    parameter int unsigned SINCOS_WIDTH = SC_W_DEF,
    parameter int unsigned POS_WIDTH    = POS_W_DEF,
    parameter int unsigned MULT_STAGES  = MULT_STAGES_DEF
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic signed [SINCOS_WIDTH-1:0] cos_phi_in,
    input  logic signed [SINCOS_WIDTH-1:0] sin_phi_in,
    input  logic signed [SINCOS_WIDTH-1:0] cos_theta_in,
    input  logic signed [SINCOS_WIDTH-1:0] sin_theta_in,
    input  logic signed [POS_WIDTH-1:0]    mag_in,
    input  logic [3*POS_WIDTH-1:0]         target_in,
    input  logic                           valid_in,
    output logic                           ready_out,
    output logic [3*POS_WIDTH-1:0]         pos_out,
    output logic [3*SINCOS_WIDTH-1:0]      u_out,
    output logic [3*SINCOS_WIDTH-1:0]      v_out,
    output logic [3*SINCOS_WIDTH-1:0]      n_out,
    output logic                           ovf_out,
    output logic                           valid_out,
    input  logic                           ready_in
);

    localparam int unsigned SC      = SINCOS_WIDTH;
    localparam int unsigned PW      = POS_WIDTH;
    localparam int unsigned LAT     = pipe_latency(MULT_STAGES);
    localparam int unsigned SIDE1_W = 4 * SC + 4 * PW;
    localparam int unsigned SIDE2_W = 9 * SC + 3 * PW;

    function automatic logic [SC-1:0] neg_sc(input logic [SC-1:0] x);
        return SC'(sat_neg(32'(signed'(x)), SC));
    endfunction

    // Returns {ovf, z, y, x} of target + mag product, clamped to PW bits per axis.
    function automatic logic [3*PW:0] add_pos(input logic [3*PW-1:0] t,
                                              input logic [3*PW-1:0] m);
        vec3_w_t tw;
        vec3_w_t mw;
        sat3_t   r;
        for (int i = 0; i < 3; i++) begin
            tw[i] = 32'(signed'(t[i*PW +: PW]));
            mw[i] = 32'(signed'(m[i*PW +: PW]));
        end
        r = sat_add3(tw, mw, PW);
        return {r.ovf, PW'(r.sum[2]), PW'(r.sum[1]), PW'(r.sum[0])};
    endfunction

    // Single global enable: the whole pipe holds while the output beat is refused.
    logic stall;
    logic en;
    assign stall     = valid_out && !ready_in;
    assign en        = !stall;
    assign ready_out = en;

    // Input register: operands load only on an input transfer.
    logic signed [SC-1:0] cphi_q, sphi_q, cth_q, sth_q;
    logic signed [PW-1:0] mag_q;
    logic [3*PW-1:0]      tgt_q;
    logic                 vld0_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cphi_q <= '0;
            sphi_q <= '0;
            cth_q  <= '0;
            sth_q  <= '0;
            mag_q  <= '0;
            tgt_q  <= '0;
            vld0_q <= 1'b0;
        end else if (en) begin
            vld0_q <= valid_in;
            if (valid_in) begin
                cphi_q <= cos_phi_in;
                sphi_q <= sin_phi_in;
                cth_q  <= cos_theta_in;
                sth_q  <= sin_theta_in;
                mag_q  <= mag_in;
                tgt_q  <= target_in;
            end
        end
    end

    // First product layer.
    logic signed [SC-1:0] p_stcp, p_spst, p_cpct, p_spct;

    fixed_point_mult #(.WA(SC), .WB(SC), .WO(SC), .FRAC(FRAC), .STAGES(MULT_STAGES)) u_m_stcp (
        .clk_i(clk_in), .rst_ni(rst_n_in), .en_i(en), .a_i(sth_q), .b_i(cphi_q), .p_o(p_stcp));
    fixed_point_mult #(.WA(SC), .WB(SC), .WO(SC), .FRAC(FRAC), .STAGES(MULT_STAGES)) u_m_spst (
        .clk_i(clk_in), .rst_ni(rst_n_in), .en_i(en), .a_i(sphi_q), .b_i(sth_q), .p_o(p_spst));
    fixed_point_mult #(.WA(SC), .WB(SC), .WO(SC), .FRAC(FRAC), .STAGES(MULT_STAGES)) u_m_cpct (
        .clk_i(clk_in), .rst_ni(rst_n_in), .en_i(en), .a_i(cphi_q), .b_i(cth_q), .p_o(p_cpct));
    fixed_point_mult #(.WA(SC), .WB(SC), .WO(SC), .FRAC(FRAC), .STAGES(MULT_STAGES)) u_m_spct (
        .clk_i(clk_in), .rst_ni(rst_n_in), .en_i(en), .a_i(sphi_q), .b_i(cth_q), .p_o(p_spct));

    // Raw operands travel alongside the first layer.
    logic [SIDE1_W-1:0]   side1;
    logic signed [SC-1:0] cphi1, sphi1, cth1, sth1;
    logic signed [PW-1:0] mag1;
    logic [3*PW-1:0]      tgt1;

    stall_delay #(.WIDTH(SIDE1_W), .DEPTH(MULT_STAGES)) u_side1 (
        .clk_i (clk_in),
        .rst_ni(rst_n_in),
        .en_i  (en),
        .d_i   ({sphi_q, cphi_q, sth_q, cth_q, mag_q, tgt_q}),
        .q_o   (side1)
    );
    assign {sphi1, cphi1, sth1, cth1, mag1, tgt1} = side1;

    // Valid bit spans both multiplier layers.
    logic vld2;
    stall_delay #(.WIDTH(1), .DEPTH(LAT - 2)) u_vld (
        .clk_i (clk_in),
        .rst_ni(rst_n_in),
        .en_i  (en),
        .d_i   (vld0_q),
        .q_o   (vld2)
    );

    // Basis vectors are complete after the first layer; pack as {z, y, x}.
    logic [3*SC-1:0] u1, v1, n1;
    assign u1 = {SC'(0), cphi1, neg_sc(sphi1)};
    assign v1 = {neg_sc(sth1), p_spct, p_cpct};
    assign n1 = {neg_sc(cth1), neg_sc(p_spst), neg_sc(p_stcp)};

    // Mag product layer: mag * (sin_t*cos_p, sin_p*sin_t, cos_t).
    logic signed [PW-1:0] m_x, m_y, m_z;

    fixed_point_mult #(.WA(PW), .WB(SC), .WO(PW), .FRAC(FRAC), .STAGES(MULT_STAGES)) u_m_px (
        .clk_i(clk_in), .rst_ni(rst_n_in), .en_i(en), .a_i(mag1), .b_i(p_stcp), .p_o(m_x));
    fixed_point_mult #(.WA(PW), .WB(SC), .WO(PW), .FRAC(FRAC), .STAGES(MULT_STAGES)) u_m_py (
        .clk_i(clk_in), .rst_ni(rst_n_in), .en_i(en), .a_i(mag1), .b_i(p_spst), .p_o(m_y));
    fixed_point_mult #(.WA(PW), .WB(SC), .WO(PW), .FRAC(FRAC), .STAGES(MULT_STAGES)) u_m_pz (
        .clk_i(clk_in), .rst_ni(rst_n_in), .en_i(en), .a_i(mag1), .b_i(cth1), .p_o(m_z));

    // Basis and target wait for the mag products.
    logic [SIDE2_W-1:0] side2;
    logic [3*SC-1:0]    u2, v2, n2;
    logic [3*PW-1:0]    tgt2;

    stall_delay #(.WIDTH(SIDE2_W), .DEPTH(MULT_STAGES)) u_side2 (
        .clk_i (clk_in),
        .rst_ni(rst_n_in),
        .en_i  (en),
        .d_i   ({n1, v1, u1, tgt1}),
        .q_o   (side2)
    );
    assign {n2, v2, u2, tgt2} = side2;

    logic [3*PW:0] pos_sum_c;
    assign pos_sum_c = add_pos(tgt2, {m_z, m_y, m_x});

    // Saturating add and output register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_out <= 1'b0;
            ovf_out   <= 1'b0;
            pos_out   <= '0;
            u_out     <= '0;
            v_out     <= '0;
            n_out     <= '0;
        end else if (en) begin
            valid_out <= vld2;
            ovf_out   <= vld2 && pos_sum_c[3*PW];
            pos_out   <= pos_sum_c[3*PW-1:0];
            u_out     <= u2;
            v_out     <= v2;
            n_out     <= n2;
        end
    end

endmodule

// File: tb/tb_camera_basis_pipe.sv
// Randomised self-checking bench for camera_basis_pipe against a scoreboard model.
module tb_camera_basis_pipe;

    localparam int unsigned FRAC = 14;
    localparam int unsigned SC   = 16;
    localparam int unsigned PW   = 18;
    localparam int unsigned MS   = 2;
    localparam int          LAT  = 2 * MS + 2;

    logic                 clk_in = 1'b0;
    logic                 rst_n_in;
    logic signed [SC-1:0] cos_phi_in, sin_phi_in, cos_theta_in, sin_theta_in;
    logic signed [PW-1:0] mag_in;
    logic [3*PW-1:0]      target_in;
    logic                 valid_in, ready_out;
    logic [3*PW-1:0]      pos_out;
    logic [3*SC-1:0]      u_out, v_out, n_out;
    logic                 ovf_out, valid_out, ready_in;

    always #5 clk_in = ~clk_in;

    camera_basis_pipe #(
        .FRAC(FRAC), .SINCOS_WIDTH(SC), .POS_WIDTH(PW), .MULT_STAGES(MS)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .cos_phi_in(cos_phi_in), .sin_phi_in(sin_phi_in),
        .cos_theta_in(cos_theta_in), .sin_theta_in(sin_theta_in),
        .mag_in(mag_in), .target_in(target_in),
        .valid_in(valid_in), .ready_out(ready_out),
        .pos_out(pos_out), .u_out(u_out), .v_out(v_out), .n_out(n_out),
        .ovf_out(ovf_out), .valid_out(valid_out), .ready_in(ready_in)
    );

    typedef struct {
        logic [3*PW-1:0] pos;
        logic [3*SC-1:0] u, v, n;
        logic            ovf;
        int              cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    bit     chk_lat = 1'b0;
    bit     last_in_xfer = 1'b0;
    longint cur_cp, cur_sp, cur_ct, cur_st, cur_mag, cur_tx, cur_ty, cur_tz;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic longint wrapw(input longint x, input int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = x & (m - 1);
        if (r >= (m >> 1)) r -= m;
        return r;
    endfunction

    function automatic longint mulfx(input longint a, input longint b, input int w);
        return wrapw((a * b) >>> FRAC, w);
    endfunction

    function automatic longint negsc(input longint x);
        longint lo;
        lo = -(longint'(1) << (SC - 1));
        return (x == lo) ? -lo - 1 : -x;
    endfunction

    function automatic logic [3*SC-1:0] pack_sc(input longint x, input longint y, input longint z);
        return {SC'(z), SC'(y), SC'(x)};
    endfunction

    // Expected beat straight from the defining equations.
    function automatic exp_t model(input int c);
        exp_t   e;
        longint dx, dy, s, hi, lo;
        longint t[3];
        longint m[3];
        hi = (longint'(1) << (PW - 1)) - 1;
        lo = -hi - 1;
        dx = mulfx(cur_st, cur_cp, SC);
        dy = mulfx(cur_sp, cur_st, SC);
        m[0] = mulfx(cur_mag, dx, PW);
        m[1] = mulfx(cur_mag, dy, PW);
        m[2] = mulfx(cur_mag, cur_ct, PW);
        t[0] = cur_tx; t[1] = cur_ty; t[2] = cur_tz;
        e.ovf = 1'b0;
        e.pos = '0;
        for (int i = 0; i < 3; i++) begin
            s = t[i] + m[i];
            if (s > hi) begin s = hi; e.ovf = 1'b1; end
            else if (s < lo) begin s = lo; e.ovf = 1'b1; end
            e.pos[i*PW +: PW] = PW'(s);
        end
        e.u   = pack_sc(negsc(cur_sp), cur_cp, 0);
        e.v   = pack_sc(mulfx(cur_cp, cur_ct, SC), mulfx(cur_sp, cur_ct, SC), negsc(cur_st));
        e.n   = pack_sc(negsc(dx), negsc(dy), negsc(cur_ct));
        e.cyc = c;
        return e;
    endfunction

    task automatic set_beat(input longint cp, input longint sp, input longint ct, input longint st,
                            input longint mg, input longint tx, input longint ty, input longint tz);
        cur_cp = cp; cur_sp = sp; cur_ct = ct; cur_st = st;
        cur_mag = mg; cur_tx = tx; cur_ty = ty; cur_tz = tz;
        cos_phi_in   = SC'(cp);
        sin_phi_in   = SC'(sp);
        cos_theta_in = SC'(ct);
        sin_theta_in = SC'(st);
        mag_in       = PW'(mg);
        target_in    = {PW'(tz), PW'(ty), PW'(tx)};
    endtask

    task automatic rand_beat();
        set_beat(wrapw(longint'($urandom), SC), wrapw(longint'($urandom), SC),
                 wrapw(longint'($urandom), SC), wrapw(longint'($urandom), SC),
                 wrapw(longint'($urandom), PW), wrapw(longint'($urandom), PW),
                 wrapw(longint'($urandom), PW), wrapw(longint'($urandom), PW));
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        exp_t          e;
        logic          stall;
        logic [199:0]  snap;
        #1;
        stall = valid_out && !ready_in;
        check_eq("ready_out", 64'(ready_out), 64'(!stall));
        if (valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_beat", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("pos", 64'(pos_out), 64'(e.pos));
                check_eq("u", 64'(u_out), 64'(e.u));
                check_eq("v", 64'(v_out), 64'(e.v));
                check_eq("n", 64'(n_out), 64'(e.n));
                check_eq("ovf", 64'(ovf_out), 64'(e.ovf));
                if (chk_lat) check_eq("latency", 64'(cyc - e.cyc), 64'(LAT));
            end
        end
        last_in_xfer = valid_in && ready_out;
        if (last_in_xfer) exp_q.push_back(model(cyc));
        snap = {pos_out, u_out, v_out, n_out, ovf_out, valid_out};
        @(posedge clk_in);
        @(negedge clk_in);
        cyc++;
        if (stall) begin
            #1;
            check_eq("stall_hold", 64'(snap == {pos_out, u_out, v_out, n_out, ovf_out, valid_out}), 64'(1));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        while (exp_q.size() != 0 && n < 60) begin
            cycle();
            n++;
        end
        check_eq("drain_timeout", 64'(exp_q.size()), 64'(0));
        repeat (LAT + 2) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent;
        int c;
        rst_n_in = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        set_beat(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk_in);
        #1;
        check_eq("rst_valid", 64'(valid_out), 64'(0));
        check_eq("rst_ready", 64'(ready_out), 64'(1));
        check_eq("rst_ovf", 64'(ovf_out), 64'(0));
        check_eq("rst_pos", 64'(pos_out), 64'(0));
        check_eq("rst_uvn", 64'(u_out | v_out | n_out), 64'(0));
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // Nominal, target offset, saturation followed by a clean beat, negation edge.
        chk_lat = 1'b1;
        set_beat(16384, 0, 0, 16384, 32768, 0, 0, 0);
        valid_in = 1'b1; cycle(); drain();
        set_beat(16384, 0, 0, 16384, 32768, 100, -200, 300);
        valid_in = 1'b1; cycle(); drain();
        set_beat(16384, 0, 0, 16384, 16384, 131071, 0, 0);
        valid_in = 1'b1; cycle();
        set_beat(16384, 0, 0, 16384, 16384, 5, 6, 7);
        cycle(); drain();
        set_beat(0, -32768, 16384, 0, 1000, 0, 0, 0);
        valid_in = 1'b1; cycle(); drain();

        // Back-pressure: ten distinct beats, ready_in low on stream cycles 8..10.
        chk_lat = 1'b0;
        sent = 0;
        c = 0;
        rand_beat();
        while (sent < 10 && c < 40) begin
            valid_in = 1'b1;
            ready_in = !(c >= 8 && c <= 10);
            cycle();
            if (last_in_xfer) begin
                sent++;
                rand_beat();
            end
            c++;
        end
        check_eq("bp_sent", 64'(sent), 64'(10));
        drain();

        // Random valid/ready traffic.
        for (int i = 0; i < 300; i++) begin
            rand_beat();
            valid_in = ($urandom_range(0, 3) != 0);
            ready_in = ($urandom_range(0, 4) != 0);
            cycle();
        end
        drain();

        // Reset with four beats in flight.
        for (int i = 0; i < 4; i++) begin
            rand_beat();
            valid_in = 1'b1;
            cycle();
        end
        valid_in = 1'b0;
        rst_n_in = 1'b0;
        #1;
        check_eq("midrst_valid", 64'(valid_out), 64'(0));
        check_eq("midrst_ovf", 64'(ovf_out), 64'(0));
        check_eq("midrst_ready", 64'(ready_out), 64'(1));
        check_eq("midrst_pos", 64'(pos_out), 64'(0));
        exp_q.delete();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk_lat = 1'b1;
        rand_beat();
        valid_in = 1'b1;
        cycle();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/camera_basis_pipe.md
# camera_basis_pipe

Fully pipelined, back-pressurable generator of the camera basis (u, v, n) and world-space position from spherical angles, orbit radius and look-at target. It is the parametrised successor to the team's fixed-latency camera block: multiplier latency is configurable, the orbit is centred on an arbitrary target, position arithmetic saturates, and a valid/ready handshake on both sides lets it sit between the orbit-angle LUT and the projection setup stage.

## Interface
Parameters:
- FRAC, 14: fractional bits of all fixed-point quantities.
- SINCOS_WIDTH, 16: signed width of sin/cos inputs and u/v/n outputs.
- POS_WIDTH, 18: signed width of mag, target and position.
- MULT_STAGES, 2: register stages inside each fixed-point multiplier; must be ≥1.

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  reset, asynchronous and active-low.
- cos_phi_in, sin_phi_in, cos_theta_in, sin_theta_in  in  SINCOS_WIDTH each  signed angle terms.
- mag_in  in  POS_WIDTH  signed orbit radius.
- target_in  in  3×POS_WIDTH  signed orbit centre (x, y, z).
- valid_in  in  1  input beat valid.
- ready_out  out  1  block accepts a beat this cycle.
- pos_out  out  3×POS_WIDTH  camera position.
- u_out, v_out, n_out  out  3×SINCOS_WIDTH each  basis vectors.
- ovf_out  out  1  position of this beat saturated on at least one axis.
- valid_out  out  1  output beat valid.
- ready_in  in  1  downstream accepts the beat.

## Operation
- Transfer on input when valid_in && ready_out; on output when valid_out && ready_in.
- Per beat, in FRAC fixed point (products truncated to FRAC, as fixed_point_mult does):
  - u = (−sinφ, cosφ, 0).
  - v = (cosφ·cosθ, sinφ·cosθ, −sinθ).
  - n = (−sinθ·cosφ, −sinφ·sinθ, −cosθ).
  - pos = target + mag·(sinθ·cosφ, sinφ·sinθ, cosθ).
- Negation saturates: −(−2^(SINCOS_WIDTH−1)) yields 2^(SINCOS_WIDTH−1)−1.
- Position add is computed at POS_WIDTH+1 bits and clamped to [−2^(POS_WIDTH−1), 2^(POS_WIDTH−1)−1] per axis. ovf_out is the OR of the three clamp events for that beat.
- Inputs are captured only on an input transfer; there is no combinational hold-through.
- Every beat carries its own operands. Successive beats never mix.

## Timing
- Latency L = 2·MULT_STAGES + 2 cycles from input transfer to valid_out, with no stall (6 at default). Stages:
  - input register.
  - first product layer.
  - mag product layer.
  - saturating add/output register.
- The u/v/n terms are delayed to align with pos.
- Throughput is one beat per cycle.
- Global stall: stall = valid_out && !ready_in. While stalled:
  - every pipeline register, including valid bits, holds.
  - ready_out = !stall.
  - all outputs are stable.
- Bubbles do not collapse under stall. This is accepted: with the simple global enable, ready_out depends only on output-register state.
- valid_out deasserts the cycle after an output transfer unless the next stage holds a valid beat.
- Simultaneous input transfer and output transfer in the same cycle is legal and loses nothing.
- Reset (rst_n_in low, any time, including mid-stream):
  - all valid bits and ovf_out go to 0 immediately.
  - pos_out, u_out, v_out and n_out go to 0.
  - ready_out is 1 during and after reset.
  - in-flight beats are discarded.
  - the first input transfer after release appears exactly L cycles later.

## Structure
- camera_pkg:
  - vec3_pos_t and vec3_sc_t packed 3-element vector typedefs.
  - function sat_neg.
  - function sat_add3.
  - localparam formula for L.
- Reuse fixed_point_mult with a MULT_STAGES parameter, gated by the stall enable.
- Sub-module stall_delay: a parametrised width/depth shift register with enable and async active-low clear. It aligns u/v/n and the valid bits.

## Test plan
Test 1, nominal: FRAC=14, θ=90°, φ=0 (sinθ=16384, cosθ=0, sinφ=0, cosφ=16384), mag=32768, target=0.
- Exactly 6 cycles later: pos=(32768,0,0), u=(0,16384,0), v=(0,0,−16384), n=(−16384,0,0), ovf=0.

Test 2, target offset: same angles, target=(100,−200,300).
- pos=(32868,−200,300).

Test 3, saturation: θ=90°, φ=0, mag=16384, target.x=131071.
- pos.x=131071, ovf_out=1.
- Next clean beat returns ovf_out=0.

Test 4, back-pressure: stream 10 distinct beats, drop ready_in for cycles 8–10.
- ready_out is low exactly while valid_out && !ready_in.
- Outputs stay frozen during the stall.
- All 10 beats arrive in order, none duplicated or dropped.

Test 5, negation edge: sinφ=−32768.
- u.x=32767.

Test 6, reset mid-stream: assert rst_n_in for one cycle with 4 beats in flight.
- All valids are 0 asynchronously.
- No stale beat emerges.
- A beat issued after release emerges at L cycles.
